// File: rtl/proc_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: fn codes, FSM states
// and the fn classifier (mul vs div, operand signedness, upper/remainder select).
package proc_muldiv_pkg;

  localparam logic [2:0] FN_MUL    = 3'd0;
  localparam logic [2:0] FN_MULH   = 3'd1;
  localparam logic [2:0] FN_MULHSU = 3'd2;
  localparam logic [2:0] FN_MULHU  = 3'd3;
  localparam logic [2:0] FN_DIV    = 3'd4;
  localparam logic [2:0] FN_DIVU   = 3'd5;
  localparam logic [2:0] FN_REM    = 3'd6;
  localparam logic [2:0] FN_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // sel_upper: high product half for multiplies, remainder for divides.
  typedef struct packed {
    logic is_div;
    logic a_signed;
    logic b_signed;
    logic sel_upper;
  } fn_class_t;

  function automatic fn_class_t classify_fn(input logic [2:0] fn);
    fn_class_t c;
    c = '0;
    case (fn)
      FN_MUL:    c = fn_class_t'(4'b0000);
      FN_MULH:   c = fn_class_t'(4'b0111);
      FN_MULHSU: c = fn_class_t'(4'b0101);
      FN_MULHU:  c = fn_class_t'(4'b0001);
      FN_DIV:    c = fn_class_t'(4'b1110);
      FN_DIVU:   c = fn_class_t'(4'b1000);
      FN_REM:    c = fn_class_t'(4'b1111);
      FN_REMU:   c = fn_class_t'(4'b1001);
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/proc_muldiv_step.sv
// One iteration of the muldiv datapath: shift-add multiply (mode=0) or
// restoring trial-subtract divide (mode=1) over shared acc/sh/op registers.
module proc_muldiv_step
  import proc_muldiv_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic                 mode,
  input  logic [2*p_nbits-1:0] acc,
  input  logic [2*p_nbits-1:0] sh,
  input  logic [p_nbits-1:0]   op,
  output logic [2*p_nbits-1:0] acc_nxt,
  output logic [2*p_nbits-1:0] sh_nxt,
  output logic [p_nbits-1:0]   op_nxt
);

  // Divide: acc[p_nbits:0] is the partial remainder, op shifts dividend bits
  // out at the top while quotient bits enter at the bottom, sh holds the divisor.
  logic [p_nbits:0]   shifted;
  logic [p_nbits+1:0] diff;

  always_comb begin
    shifted = {acc[p_nbits-1:0], op[p_nbits-1]};
    diff    = {1'b0, shifted} - {2'b00, sh[p_nbits-1:0]};
    acc_nxt = acc;
    sh_nxt  = sh;
    op_nxt  = op;
    if (!mode) begin
      if (op[0]) acc_nxt = acc + sh;
      sh_nxt = {sh[2*p_nbits-2:0], 1'b0};
      op_nxt = {1'b0, op[p_nbits-1:1]};
    end else begin
      acc_nxt = '0;
      if (!diff[p_nbits+1]) acc_nxt[p_nbits:0] = diff[p_nbits:0];
      else                  acc_nxt[p_nbits:0] = shifted;
      op_nxt = {op[p_nbits-2:0], ~diff[p_nbits+1]};
    end
  end

endmodule

// File: rtl/proc_muldiv_unit.sv
// Iterative RV32M multiply/divide unit with val/rdy streams, p_nbits+1 cycle latency.
// Define PROC_MULDIV_EARLY_EXIT_EN for early multiply exit and immediate divide-by-zero.
module proc_muldiv_unit
  import proc_muldiv_pkg::*;
#(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2:0]         istream_msg_fn,
  input  logic [p_nbits-1:0] istream_msg_a,
  input  logic [p_nbits-1:0] istream_msg_b,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] ostream_msg
);

  localparam int N  = p_nbits;
  localparam int CW = $clog2(p_nbits + 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  fn_class_t         cls, cls_q;
  logic              neg_q, res_neg, a_neg, b_neg, calc_exit;
  logic [N-1:0]      mag_a, mag_b, op, op_nxt, msg, result;
  logic [N-1:0]      quo_fix, rem_fix;
  logic [2*N-1:0]    acc, sh, acc_nxt, sh_nxt, prod_fix;

  // Handshake: a request is taken when istream_val & istream_rdy at a clock edge,
  // a result is released when ostream_val & ostream_rdy; both valid/ready outputs
  // depend only on state and reset.
  assign istream_rdy = (state == ST_IDLE) & ~reset;
  assign ostream_val = (state == ST_DONE) & ~reset;
  assign ostream_msg = msg;

  always_comb begin
    cls   = classify_fn(istream_msg_fn);
    a_neg = cls.a_signed & istream_msg_a[N-1];
    b_neg = cls.b_signed & istream_msg_b[N-1];
    mag_a = a_neg ? -istream_msg_a : istream_msg_a;
    mag_b = b_neg ? -istream_msg_b : istream_msg_b;
    // Divide by zero keeps a positive all-ones quotient; remainder follows a.
    if (!cls.is_div)       res_neg = a_neg ^ b_neg;
    else if (cls.sel_upper) res_neg = a_neg;
    else                    res_neg = (a_neg ^ b_neg) & (istream_msg_b != '0);
  end

  proc_muldiv_step #(.p_nbits(N)) u_step (
    .mode    (cls_q.is_div),
    .acc     (acc),
    .sh      (sh),
    .op      (op),
    .acc_nxt (acc_nxt),
    .sh_nxt  (sh_nxt),
    .op_nxt  (op_nxt)
  );

  always_comb begin
    calc_exit = (cnt == '0);
`ifdef PROC_MULDIV_EARLY_EXIT_EN
    if (cls_q.is_div ? (sh[N-1:0] == '0) : (op == '0)) calc_exit = 1'b1;
`endif
  end

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -op : op;
    rem_fix  = neg_q ? -acc[N-1:0] : acc[N-1:0];
    if (!cls_q.is_div) result = cls_q.sel_upper ? prod_fix[2*N-1:N] : prod_fix[N-1:0];
    else               result = cls_q.sel_upper ? rem_fix : quo_fix;
`ifdef PROC_MULDIV_EARLY_EXIT_EN
    // No iterations ran: op still holds |a|, so the signed-fixed op is a itself.
    if (cls_q.is_div && (sh[N-1:0] == '0)) result = cls_q.sel_upper ? quo_fix : '1;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (istream_val) state_nxt = ST_CALC;
      ST_CALC: if (calc_exit)   state_nxt = ST_DONE;
      ST_DONE: if (ostream_rdy) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      cls_q <= '0;
      neg_q <= 1'b0;
      acc   <= '0;
      sh    <= '0;
      op    <= '0;
      msg   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (istream_val) begin
          cls_q <= cls;
          neg_q <= res_neg;
          cnt   <= CW'(N);
          acc   <= '0;
          if (cls.is_div) begin
            sh <= {{N{1'b0}}, mag_b};
            op <= mag_a;
          end else begin
            sh <= {{N{1'b0}}, mag_a};
            op <= mag_b;
          end
        end
        ST_CALC: if (calc_exit) begin
          msg <= result;
        end else begin
          acc <= acc_nxt;
          sh  <= sh_nxt;
          op  <= op_nxt;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
